// File: rtl/sdram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sdram_ctrl
//  Description : SDRAM command sequencer. Runs the power-up init sequence and
//                then arbitrates refresh / write / read bursts, exposing the
//                init and work state machines and the shared cycle counter.
//  Revision    : 1.0 - initial release
// ============================================================================

package sdram_ctrl_pkg;

  typedef enum logic [4:0] {
    I_NOP  = 5'd0,
    I_PRE  = 5'd1,
    I_TRP  = 5'd2,
    I_AR   = 5'd3,
    I_TRF  = 5'd4,
    I_MRS  = 5'd5,
    I_TRSC = 5'd6,
    I_DONE = 5'd7
  } init_state_t;

  typedef enum logic [3:0] {
    W_IDLE   = 4'd0,
    W_ACTIVE = 4'd1,
    W_TRCD   = 4'd2,
    W_READ   = 4'd3,
    W_CL     = 4'd4,
    W_RD     = 4'd5,
    W_WRITE  = 4'd6,
    W_WD     = 4'd7,
    W_TWR    = 4'd8,
    W_PRE    = 4'd9,
    W_TRP    = 4'd10,
    W_AR     = 4'd11,
    W_TRFC   = 4'd12
  } work_state_t;

endpackage

module sdram_ctrl
  import sdram_ctrl_pkg::*;
#(
  parameter int T_POWER     = 20000,
  parameter int TRP_CLK     = 2,
  parameter int TRFC_CLK    = 7,
  parameter int TRSC_CLK    = 2,
  parameter int TRCD_CLK    = 2,
  parameter int TCL_CLK     = 3,
  parameter int TWR_CLK     = 2,
  parameter int REF_PERIOD  = 780,
  parameter int INIT_AR_CNT = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sdram_wr_req,
  input  logic       sdram_rd_req,
  input  logic [9:0] sdram_wr_burst,
  input  logic [9:0] sdram_rd_burst,
  output logic       sdram_wr_ack,
  output logic       sdram_rd_ack,
  output logic       sdram_init_done,
  output logic [4:0] init_state,
  output logic [3:0] work_state,
  output logic [9:0] cnt_clk,
  output logic       sdram_rd_wr
);

  // Counter widths; the power-up wait may exceed what cnt_clk can hold,
  // so it gets its own counter.
  localparam int PW = (T_POWER > 1) ? $clog2(T_POWER) : 1;
  localparam int RW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int AW = $clog2(INIT_AR_CNT + 1);

  localparam logic [PW-1:0] PWR_LAST  = PW'(T_POWER - 1);
  localparam logic [RW-1:0] REF_LAST  = RW'(REF_PERIOD - 1);
  localparam logic [AW-1:0] AR_TOTAL  = AW'(INIT_AR_CNT);
  localparam logic [9:0]    TRP_LAST  = 10'(TRP_CLK - 1);
  localparam logic [9:0]    TRFC_LAST = 10'(TRFC_CLK - 1);
  localparam logic [9:0]    TRSC_LAST = 10'(TRSC_CLK - 1);
  localparam logic [9:0]    TRCD_LAST = 10'(TRCD_CLK - 1);
  localparam logic [9:0]    TWR_LAST  = 10'(TWR_CLK - 1);
  // W_CL lasts TCL_CLK-1 cycles; unused when TCL_CLK is 1.
  localparam logic [9:0]    CL_LAST   = 10'(TCL_CLK - 2);
  localparam logic [9:0]    CNT_MAX   = 10'd1023;

  init_state_t   init_q, init_d;
  work_state_t   work_q, work_d;
  logic [9:0]    cnt_q;
  logic [PW-1:0] pwr_cnt;
  logic [RW-1:0] ref_cnt;
  logic          ref_pend;
  logic [AW-1:0] ar_cnt;
  logic [9:0]    burst_len;
  logic          rd_wr_q;
  logic          grant_wr;
  logic          grant_rd;
  logic [9:0]    burst_m1;
  logic [9:0]    burst_m2;

  assign burst_m1 = burst_len - 10'd1;
  assign burst_m2 = burst_len - 10'd2;

  // Zero-length bursts behave as one word, long ones cap at 512 words.
  function automatic logic [9:0] clamp_burst(input logic [9:0] b);
    if (b == 10'd0)        return 10'd1;
    else if (b > 10'd512)  return 10'd512;
    else                   return b;
  endfunction

  // Init sequence next-state decode.
  always_comb begin
    init_d = init_q;
    case (init_q)
      I_NOP:   if (pwr_cnt == PWR_LAST) init_d = I_PRE;
      I_PRE:   init_d = I_TRP;
      I_TRP:   if (cnt_q == TRP_LAST) init_d = I_AR;
      I_AR:    init_d = I_TRF;
      I_TRF:   if (cnt_q == TRFC_LAST) init_d = (ar_cnt == AR_TOTAL) ? I_MRS : I_AR;
      I_MRS:   init_d = I_TRSC;
      I_TRSC:  if (cnt_q == TRSC_LAST) init_d = I_DONE;
      I_DONE:  init_d = I_DONE;
      default: init_d = I_NOP;
    endcase
  end

  // Work state next-state decode with refresh > write > read arbitration.
  always_comb begin
    work_d   = work_q;
    grant_wr = 1'b0;
    grant_rd = 1'b0;
    case (work_q)
      W_IDLE: begin
        if (init_q == I_DONE) begin
          if (ref_pend) begin
            work_d = W_AR;
          end else if (sdram_wr_req) begin
            work_d   = W_ACTIVE;
            grant_wr = 1'b1;
          end else if (sdram_rd_req) begin
            work_d   = W_ACTIVE;
            grant_rd = 1'b1;
          end
        end
      end
      W_ACTIVE: work_d = W_TRCD;
      W_TRCD:   if (cnt_q == TRCD_LAST) work_d = rd_wr_q ? W_READ : W_WRITE;
      W_WRITE:  work_d = (burst_len == 10'd1) ? W_TWR : W_WD;
      W_WD:     if (cnt_q == burst_m2) work_d = W_TWR;
      W_TWR:    if (cnt_q == TWR_LAST) work_d = W_PRE;
      W_READ:   work_d = (TCL_CLK > 1) ? W_CL : W_RD;
      W_CL:     if (cnt_q == CL_LAST) work_d = W_RD;
      W_RD:     if (cnt_q == burst_m1) work_d = W_PRE;
      W_PRE:    work_d = W_TRP;
      W_TRP:    if (cnt_q == TRP_LAST) work_d = W_IDLE;
      W_AR:     work_d = W_TRFC;
      W_TRFC:   if (cnt_q == TRFC_LAST) work_d = W_IDLE;
      default:  work_d = W_IDLE;
    endcase
  end

  // State registers and the shared per-state cycle counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      init_q <= I_NOP;
      work_q <= W_IDLE;
      cnt_q  <= 10'd0;
    end else begin
      init_q <= init_d;
      work_q <= work_d;
      if ((init_d != init_q) || (work_d != work_q)) cnt_q <= 10'd0;
      else if (cnt_q != CNT_MAX)                    cnt_q <= cnt_q + 10'd1;
    end
  end

  // Power-up wait and init auto-refresh tally.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwr_cnt <= '0;
      ar_cnt  <= '0;
    end else begin
      if (init_q == I_NOP && pwr_cnt != PWR_LAST) pwr_cnt <= pwr_cnt + PW'(1);
      if (init_q == I_AR)                         ar_cnt  <= ar_cnt + AW'(1);
    end
  end

  // Periodic refresh request; a wrap while already pending is absorbed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ref_cnt  <= '0;
      ref_pend <= 1'b0;
    end else if (init_q == I_DONE) begin
      if (ref_cnt == REF_LAST) ref_cnt <= '0;
      else                     ref_cnt <= ref_cnt + RW'(1);
      if (work_q == W_IDLE && work_d == W_AR) ref_pend <= 1'b0;
      else if (ref_cnt == REF_LAST)           ref_pend <= 1'b1;
    end
  end

  // Direction and burst length captured at grant, held for the transaction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_wr_q   <= 1'b1;
      burst_len <= 10'd1;
    end else if (grant_wr || grant_rd) begin
      rd_wr_q   <= grant_rd;
      burst_len <= clamp_burst(grant_rd ? sdram_rd_burst : sdram_wr_burst);
    end
  end

  assign sdram_wr_ack    = (work_q == W_WRITE) || (work_q == W_WD);
  assign sdram_rd_ack    = (work_q == W_RD);
  assign sdram_init_done = (init_q == I_DONE);
  assign init_state      = init_q;
  assign work_state      = work_q;
  assign cnt_clk         = cnt_q;
  assign sdram_rd_wr     = rd_wr_q;

endmodule

`default_nettype wire
